// File: rtl/imem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_arbiter_pkg : shared types and address check for imem_arbiter  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package imem_arbiter_pkg;

   typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_e;
   typedef enum logic {OWN_FETCH = 1'b0, OWN_LOADER = 1'b1} owner_e;

   localparam int unsigned INST_NUM = 50;

   // True when a byte address is not word aligned or beyond the last word.
   function automatic logic addr_err(input logic [1:0]  byte_ofs,
                                     input logic [63:0] word_idx,
                                     input int unsigned inst_num);
      return (byte_ofs != 2'b00) || (word_idx >= 64'(inst_num));
   endfunction

endpackage
`default_nettype wire

// File: rtl/imem_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_rr_arb : 2-input round-robin arbiter, fetch port gated by f_en  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module imem_rr_arb
   import imem_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic f_en,
   input  logic f_req,
   input  logic l_req,
   output logic f_gnt,
   output logic l_gnt
);

   owner_e last_gnt_q;
   owner_e last_gnt_d;

   always_comb begin
      f_gnt      = f_en & f_req & (~l_req | (last_gnt_q == OWN_LOADER));
      l_gnt      = l_req & ~f_gnt;
      last_gnt_d = last_gnt_q;
      if (f_gnt) begin
         last_gnt_d = OWN_FETCH;
      end else if (l_gnt) begin
         last_gnt_d = OWN_LOADER;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_gnt_q <= OWN_LOADER;
      end else begin
         last_gnt_q <= last_gnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_arbiter : boot/run sharing of instruction memory, fetch+loader  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module imem_arbiter #(
   parameter int N        = 32,
   parameter int INST_NUM = imem_arbiter_pkg::INST_NUM,
   parameter int ADR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             f_req,
   input  logic [N-1:0]     f_adr,
   output logic             f_gnt,
   output logic             f_rvalid,
   output logic [N-1:0]     f_rdata,
   output logic             f_err,
   input  logic             l_req,
   input  logic             l_we,
   input  logic [N-1:0]     l_adr,
   input  logic [N-1:0]     l_wdata,
   input  logic             l_done,
   output logic             l_gnt,
   output logic             l_rvalid,
   output logic [N-1:0]     l_rdata,
   output logic             l_err,
   output logic             boot_done,
   output logic             mem_en,
   output logic             mem_we,
   output logic [ADR_W-1:0] mem_adr,
   output logic [N-1:0]     mem_wdata,
   input  logic [N-1:0]     mem_rdata
);

   import imem_arbiter_pkg::*;

   state_e     state_q, state_d;
   logic       rsp_valid_q, rsp_valid_d;
   owner_e     rsp_owner_q, rsp_owner_d;
   logic       rsp_err_q, rsp_err_d;
   logic       rsp_rd_q, rsp_rd_d;

   logic       w_any_gnt;
   logic       w_err;
   logic [N-1:0] w_adr;

   // Requests are masked during reset so the memory strobes fall at once.
   imem_rr_arb u_arb (
      .clk   (clk),
      .rst   (rst),
      .f_en  (state_q == RUN),
      .f_req (f_req & ~rst),
      .l_req (l_req & ~rst),
      .f_gnt (f_gnt),
      .l_gnt (l_gnt)
   );

   always_comb begin
      w_any_gnt = f_gnt | l_gnt;
      w_adr     = f_gnt ? f_adr : l_adr;
      w_err     = w_any_gnt & addr_err(w_adr[1:0], 64'(w_adr >> 2), INST_NUM);

      mem_en    = w_any_gnt & ~w_err;
      mem_we    = l_gnt & l_we & ~w_err;
      mem_adr   = w_any_gnt ? w_adr[ADR_W+1:2] : '0;
      mem_wdata = l_gnt ? l_wdata : '0;
   end

   // The loader's final access in BOOT still completes; state only gates fetch.
   always_comb begin
      state_d = state_q;
      if (state_q == BOOT && l_done) begin
         state_d = RUN;
      end
      rsp_valid_d = w_any_gnt;
      rsp_owner_d = f_gnt ? OWN_FETCH : OWN_LOADER;
      rsp_err_d   = w_err;
      rsp_rd_d    = w_any_gnt & ~w_err & ~(l_gnt & l_we);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= BOOT;
         rsp_valid_q <= 1'b0;
         rsp_owner_q <= OWN_LOADER;
         rsp_err_q   <= 1'b0;
         rsp_rd_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_owner_q <= rsp_owner_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rd_q    <= rsp_rd_d;
      end
   end

   always_comb begin
      boot_done = (state_q == RUN);
      f_rvalid  = rsp_valid_q & (rsp_owner_q == OWN_FETCH);
      l_rvalid  = rsp_valid_q & (rsp_owner_q == OWN_LOADER);
      f_err     = f_rvalid & rsp_err_q;
      l_err     = l_rvalid & rsp_err_q;
      f_rdata   = (f_rvalid & rsp_rd_q) ? mem_rdata : '0;
      l_rdata   = (l_rvalid & rsp_rd_q) ? mem_rdata : '0;
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imem_arbiter : scoreboard bench for imem_arbiter                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_imem_arbiter;

   localparam int N        = 32;
   localparam int INST_NUM = 50;
   localparam int ADR_W    = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             f_req = 1'b0;
   logic [N-1:0]     f_adr = '0;
   logic             f_gnt, f_rvalid, f_err;
   logic [N-1:0]     f_rdata;
   logic             l_req = 1'b0;
   logic             l_we = 1'b0;
   logic [N-1:0]     l_adr = '0;
   logic [N-1:0]     l_wdata = '0;
   logic             l_done = 1'b0;
   logic             l_gnt, l_rvalid, l_err;
   logic [N-1:0]     l_rdata;
   logic             boot_done, mem_en, mem_we;
   logic [ADR_W-1:0] mem_adr;
   logic [N-1:0]     mem_wdata;
   logic [N-1:0]     mem_rdata = '0;

   imem_arbiter #(.N(N), .INST_NUM(INST_NUM), .ADR_W(ADR_W)) dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_adr(f_adr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
      .f_rdata(f_rdata), .f_err(f_err),
      .l_req(l_req), .l_we(l_we), .l_adr(l_adr), .l_wdata(l_wdata),
      .l_done(l_done), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
      .l_err(l_err), .boot_done(boot_done),
      .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory attached to the DUT.
   logic [N-1:0] mem [256];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_adr] <= mem_wdata;
         else        mem_rdata    <= mem[mem_adr];
      end
   end

   typedef struct packed {
      logic        fv;
      logic        lv;
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   rsp_t        q[$];
   logic [31:0] exp_mem [256];
   logic        m_run;
   logic        m_last;   // 1 = loader granted most recently
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".f_gnt"},     32'(f_gnt),     0);
      check({tag, ".l_gnt"},     32'(l_gnt),     0);
      check({tag, ".f_rvalid"},  32'(f_rvalid),  0);
      check({tag, ".f_rdata"},   f_rdata,        0);
      check({tag, ".f_err"},     32'(f_err),     0);
      check({tag, ".l_rvalid"},  32'(l_rvalid),  0);
      check({tag, ".l_rdata"},   l_rdata,        0);
      check({tag, ".l_err"},     32'(l_err),     0);
      check({tag, ".boot_done"}, 32'(boot_done), 0);
      check({tag, ".mem_en"},    32'(mem_en),    0);
      check({tag, ".mem_we"},    32'(mem_we),    0);
      check({tag, ".mem_adr"},   32'(mem_adr),   0);
      check({tag, ".mem_wdata"}, mem_wdata,      0);
   endtask

   // One clock of stimulus: inputs already set; checks at negedge, model update at posedge.
   task automatic step();
      rsp_t        exp_r, prev;
      logic        fe, eg_f, eg_l, any, err, wr;
      logic [31:0] adr;
      @(negedge clk);
      fe   = f_req & m_run;
      eg_f = fe & (~l_req | m_last);
      eg_l = l_req & ~eg_f;
      any  = eg_f | eg_l;
      adr  = eg_f ? f_adr : l_adr;
      err  = any & ((adr[1:0] != 2'b00) || ((adr >> 2) >= INST_NUM));
      wr   = eg_l & l_we;
      check("f_gnt",     32'(f_gnt),     32'(eg_f));
      check("l_gnt",     32'(l_gnt),     32'(eg_l));
      check("mem_en",    32'(mem_en),    32'(any & ~err));
      check("mem_we",    32'(mem_we),    32'(wr & ~err));
      check("mem_adr",   32'(mem_adr),   any ? 32'(adr[9:2]) : 32'd0);
      check("mem_wdata", mem_wdata,      eg_l ? l_wdata : 32'd0);
      check("boot_done", 32'(boot_done), 32'(m_run));
      prev = '0;
      if (q.size() > 0) prev = q.pop_front();
      check("f_rvalid",  32'(f_rvalid),  32'(prev.fv));
      check("l_rvalid",  32'(l_rvalid),  32'(prev.lv));
      check("f_err",     32'(f_err),     32'(prev.fv & prev.err));
      check("l_err",     32'(l_err),     32'(prev.lv & prev.err));
      check("f_rdata",   f_rdata,        prev.fv ? prev.rdata : 32'd0);
      check("l_rdata",   l_rdata,        prev.lv ? prev.rdata : 32'd0);
      exp_r.fv    = eg_f;
      exp_r.lv    = eg_l;
      exp_r.err   = err;
      exp_r.rdata = (any & ~err & ~wr) ? exp_mem[adr[9:2]] : 32'd0;
      q.push_back(exp_r);
      @(posedge clk);
      if (any & ~err & wr) exp_mem[adr[9:2]] = l_wdata;
      if (eg_f)      m_last = 1'b0;
      else if (eg_l) m_last = 1'b1;
      if (l_done)    m_run  = 1'b1;
      #1;
   endtask

   task automatic idle_inputs();
      f_req = 0; l_req = 0; l_we = 0; l_done = 0;
      f_adr = '0; l_adr = '0; l_wdata = '0;
   endtask

   task automatic lwrite(input logic [31:0] a, input logic [31:0] d);
      idle_inputs(); l_req = 1; l_we = 1; l_adr = a; l_wdata = d;
      step();
   endtask

   task automatic lread(input logic [31:0] a);
      idle_inputs(); l_req = 1; l_adr = a;
      step();
   endtask

   task automatic fread(input logic [31:0] a);
      idle_inputs(); f_req = 1; f_adr = a;
      step();
   endtask

   logic [31:0] adr_tab [6];

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = '0;
         exp_mem[i] = '0;
      end
      adr_tab[0] = 32'h00; adr_tab[1] = 32'h0C; adr_tab[2] = 32'h58;
      adr_tab[3] = 32'h0E; adr_tab[4] = 32'hC8; adr_tab[5] = 32'hC4;
      m_run = 0; m_last = 1;

      // Reset state
      rst = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      rst = 0;

      // BOOT: fetch locked out
      idle_inputs(); f_req = 1; f_adr = 32'h0;
      repeat (5) step();

      // BOOT: loader writes image, reads back
      lwrite(32'h58, 32'd13);
      lwrite(32'h0C, 32'd1);
      lread(32'h58);
      idle_inputs(); step();

      // Enter RUN
      l_done = 1; step();
      idle_inputs(); step();

      // Both requesting: F,L,F,L
      f_req = 1; f_adr = 32'h0C; l_req = 1; l_adr = 32'h58;
      repeat (4) step();
      idle_inputs(); step();

      // Fetch good, misaligned, out of range
      fread(32'h0C);
      fread(32'h0E);
      fread(32'hC8);
      // Loader write out of range, then edge of range
      lwrite(32'hC8, 32'hDEAD_BEEF);
      lwrite(32'hC4, 32'h0000_0031);
      lread(32'hC4);
      idle_inputs(); l_done = 1; step();

      // Mixed traffic
      for (int i = 0; i < 40; i++) begin
         f_req   = 1'($urandom_range(0, 1));
         l_req   = 1'($urandom_range(0, 1));
         l_we    = ($urandom_range(0, 3) == 0);
         f_adr   = adr_tab[$urandom_range(0, 5)];
         l_adr   = adr_tab[$urandom_range(0, 5)];
         l_wdata = $urandom;
         l_done  = 1'($urandom_range(0, 1));
         step();
      end
      idle_inputs(); step();

      // Reset with a fetch response in flight
      fread(32'h0C);
      rst = 1; l_req = 1; l_adr = 32'h0C;
      q.delete(); m_run = 0; m_last = 1;
      @(negedge clk);
      check_all_zero("midrst");
      @(posedge clk); #1;
      rst = 0;
      fread(32'h0C);
      idle_inputs(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
